// File: rtl/mem_dump_reader.sv
// Streams word_count memory words from base_addr through a 2-entry output FIFO.
// Optional running checksum output enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     reads_left_q, reads_left_d;
    logic [ADDR_W:0]     acc_left_q, acc_left_d;
    logic                rv_q, rv_d;
    logic [1:0]          occ_q, occ_d;
    logic [DATA_W-1:0]   e0_q, e0_d;
    logic [DATA_W-1:0]   e1_q, e1_d;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    logic                valid_s;
    logic                pop_s;
    logic                issue_s;
    logic [1:0]          fill_s;

    // Output view: FIFO head first, otherwise the word returning from memory this cycle.
    always_comb begin
        valid_s = (occ_q != 2'd0) || rv_q;
        pop_s   = valid_s && out_ready;
        fill_s  = occ_q + {1'b0, rv_q} - {1'b0, pop_s};
        issue_s = (state_q == RUN) && (reads_left_q != '0) && (fill_s < 2'd2);
        if (occ_q != 2'd0) begin
            out_data = e0_q;
        end else if (rv_q) begin
            out_data = mem_rdata;
        end else begin
            out_data = '0;
        end
    end

    // Control FSM, address and count bookkeeping.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        reads_left_d = reads_left_q;
        acc_left_d   = acc_left_q;
        rv_d         = issue_s;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    reads_left_d = word_count;
                    acc_left_d   = word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d       = '0;
`endif
                    if (word_count == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    addr_d       = addr_q + ADDR_ONE;
                    reads_left_d = reads_left_q - CNT_ONE;
                end else begin
                    addr_d       = addr_q;
                end
                if (pop_s) begin
                    acc_left_d = acc_left_q - CNT_ONE;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d     = csum_q + out_data;
`endif
                    if (acc_left_q == CNT_ONE) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    acc_left_d = acc_left_q;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage: pop takes the logical head, the returning word joins at the tail.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case (occ_q)
            2'd0: begin
                if (rv_q && !pop_s) begin
                    e0_d  = mem_rdata;
                    occ_d = 2'd1;
                end else begin
                    occ_d = 2'd0;
                end
            end
            2'd1: begin
                if (pop_s) begin
                    if (rv_q) begin
                        e0_d = mem_rdata;
                    end else begin
                        occ_d = 2'd0;
                    end
                end else if (rv_q) begin
                    e1_d  = mem_rdata;
                    occ_d = 2'd2;
                end else begin
                    occ_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    e0_d = e1_q;
                    if (rv_q) begin
                        e1_d = mem_rdata;
                    end else begin
                        occ_d = 2'd1;
                    end
                end else begin
                    occ_d = 2'd2;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            reads_left_q <= '0;
            acc_left_q   <= '0;
            rv_q         <= 1'b0;
            occ_q        <= 2'd0;
            e0_q         <= '0;
            e1_q         <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            reads_left_q <= reads_left_d;
            acc_left_q   <= acc_left_d;
            rv_q         <= rv_d;
            occ_q        <= occ_d;
            e0_q         <= e0_d;
            e1_q         <= e1_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign mem_rd_en = issue_s;
    assign mem_addr  = addr_q;
    assign out_valid = valid_s;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
`ifdef MEM_DUMP_CHECKSUM_EN
    assign checksum  = csum_q;
`endif

endmodule
